// File: rtl/diffusion_step_scheduler_if.sv
// Handshake bundle between the PPR diffusion step scheduler and its environment
// (PS control registers plus the propagation and add-up datapaths).
interface diffusion_step_scheduler_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  start;
  logic [DATA_WIDTH-1:0] n_steps;
  logic                  abort;
  logic                  done_ack;
  logic                  prop_start;
  logic                  prop_done;
  logic                  addup_start;
  logic                  addup_done;
  logic [DATA_WIDTH-1:0] l_step;
  logic                  cur_bank;
  logic                  busy;
  logic                  done;
  logic                  timeout;

  modport master (
    output start, n_steps, abort, done_ack, prop_done, addup_done,
    input  prop_start, addup_start, l_step, cur_bank, busy, done, timeout
  );

  modport slave (
    input  start, n_steps, abort, done_ack, prop_done, addup_done,
    output prop_start, addup_start, l_step, cur_bank, busy, done, timeout
  );
endinterface

// File: rtl/diffusion_step_scheduler.sv
// Sequencer for one PPR diffusion run: issues per-step propagation/add-up pulses and tracks l_step.
// Optional per-phase watchdog enabled by defining STEP_WATCHDOG_EN.
module diffusion_step_scheduler #(
  parameter int DATA_WIDTH     = 32,
  parameter int MAX_STEPS      = 7,
  parameter int TIMEOUT_CYCLES = 65536
) (
  input logic                      clk,
  input logic                      rst,
  diffusion_step_scheduler_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, PROP_START, PROP_WAIT, ADD_START, ADD_WAIT, STEP_NEXT, DONE
  } state_t;

  state_t                state, state_nxt;
  logic [DATA_WIDTH-1:0] steps_q;
  logic [DATA_WIDTH-1:0] l_step_q;
  logic [DATA_WIDTH-1:0] l_step_inc;
  logic                  prop_start_q;
  logic                  addup_start_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  wd_fire;
  logic                  start_acc;

  function automatic logic [DATA_WIDTH-1:0] sat_steps(input logic [DATA_WIDTH-1:0] n);
    if (n > DATA_WIDTH'(MAX_STEPS)) sat_steps = DATA_WIDTH'(MAX_STEPS);
    else                            sat_steps = n;
  endfunction

  assign l_step_inc = l_step_q + DATA_WIDTH'(1);
  assign start_acc  = (state == IDLE) && bus.start;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:       if (bus.start) state_nxt = (sat_steps(bus.n_steps) == '0) ? DONE : PROP_START;
      PROP_START: state_nxt = PROP_WAIT;
      PROP_WAIT: begin
        if (bus.prop_done)  state_nxt = ADD_START;
        else if (wd_fire)   state_nxt = IDLE;
      end
      ADD_START:  state_nxt = ADD_WAIT;
      ADD_WAIT: begin
        if (bus.addup_done) state_nxt = STEP_NEXT;
        else if (wd_fire)   state_nxt = IDLE;
      end
      STEP_NEXT:  state_nxt = (l_step_inc == steps_q) ? DONE : PROP_START;
      DONE:       if (bus.done_ack) state_nxt = IDLE;
      default:    state_nxt = IDLE;
    endcase
    // abort outranks every completion in the same cycle
    if (bus.abort && state != IDLE && state != DONE) state_nxt = IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= IDLE;
      l_step_q      <= '0;
      prop_start_q  <= 1'b0;
      addup_start_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state         <= state_nxt;
      prop_start_q  <= (state_nxt == PROP_START);
      addup_start_q <= (state_nxt == ADD_START);
      busy_q        <= (state_nxt != IDLE) && (state_nxt != DONE);
      done_q        <= (state_nxt == DONE);
      if (start_acc)
        l_step_q <= '0;
      else if (state == STEP_NEXT && !bus.abort)
        l_step_q <= l_step_inc;
    end
  end

  always_ff @(posedge clk) begin
    if (start_acc) steps_q <= sat_steps(bus.n_steps);
  end

`ifdef STEP_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_cnt;
  logic            timeout_q;

  // A completion on the final counted cycle still wins over the watchdog.
  assign wd_fire = (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1)) &&
                   ((state == PROP_WAIT && !bus.prop_done) ||
                    (state == ADD_WAIT  && !bus.addup_done));

  always_ff @(posedge clk) begin
    if (!rst) begin
      wd_cnt    <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (state_nxt != state)
        wd_cnt <= '0;
      else if (state == PROP_WAIT || state == ADD_WAIT)
        wd_cnt <= wd_cnt + WD_W'(1);
      if (start_acc)
        timeout_q <= 1'b0;
      else if (wd_fire && !bus.abort)
        timeout_q <= 1'b1;
    end
  end

  assign bus.timeout = timeout_q;
`else
  assign wd_fire     = 1'b0;
  assign bus.timeout = 1'b0;
`endif

  assign bus.prop_start  = prop_start_q;
  assign bus.addup_start = addup_start_q;
  assign bus.l_step      = l_step_q;
  assign bus.cur_bank    = ~l_step_q[0];
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;

endmodule
